// File: rtl/mac_result_fifo.sv
// mac_result_fifo: captures valid MAC pipeline results into a FIFO and returns
// them to the Nios II as a multi-cycle custom instruction
// (POP / STATUS / CLEAR / PEEK).
// Optional feature macro: MAC_RESULT_FIFO_BYPASS_EN. When it is defined, a POP
// that is waiting on an empty FIFO takes the arriving word straight into
// result.
// Handshake: start is a one-cycle request sampled only in IDLE. done is a
// one-cycle response that carries result. There is no backpressure. While
// clk_en is low, everything freezes and done stays asserted.
module mac_result_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              in_nop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start,
  input  logic [1:0]        n,
  output logic              done,
  output logic [31:0]       result,
  output logic              full,
  output logic              empty,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_POP    = 2'b00;
  localparam logic [1:0] OP_STATUS = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PEEK   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           op_pop_q, op_pop_d;
  logic           done_q, done_d;
  logic [31:0]    result_q, result_d;

  logic           pop;
  logic           clr;
  logic           byp;
  logic           push;
  logic           wr_en;
  logic           is_full;
  logic           is_empty;
  logic [31:0]    head;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign head     = 32'(mem[rd_ptr_q]);

  // Instruction sequencing: decide pop/clear/bypass and the latched response.
  always_comb begin
    state_d  = state_q;
    op_pop_d = op_pop_q;
    done_d   = done_q;
    result_d = result_q;
    pop      = 1'b0;
    clr      = 1'b0;
    byp      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (n)
            OP_POP, OP_PEEK: begin
              if (!is_empty) begin
                result_d = head;
                pop      = (n == OP_POP);
                done_d   = 1'b1;
                state_d  = S_RESP;
              end else begin
                op_pop_d = (n == OP_POP);
                state_d  = S_WAIT;
              end
            end
            OP_STATUS: begin
              result_d = {ovf_q, 15'b0, 16'(count_q)};
              done_d   = 1'b1;
              state_d  = S_RESP;
            end
            OP_CLEAR: begin
              clr      = 1'b1;
              result_d = 32'h0;
              done_d   = 1'b1;
              state_d  = S_RESP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WAIT: begin
        // Already-queued data has priority so ordering is never violated.
        if (!is_empty) begin
          result_d = head;
          pop      = op_pop_q;
          done_d   = 1'b1;
          state_d  = S_RESP;
        end
`ifdef MAC_RESULT_FIFO_BYPASS_EN
        else if (op_pop_q && !in_nop) begin
          result_d = 32'(in_data);
          byp      = 1'b1;
          done_d   = 1'b1;
          state_d  = S_RESP;
        end
`endif
      end
      S_RESP: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write side and occupancy: a write while full succeeds only with a same-cycle pop.
  always_comb begin
    push     = !in_nop && !clr && !byp;
    wr_en    = push && (!is_full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push && is_full && !pop);
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  // Control and status registers; everything holds while clk_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      op_pop_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else if (clk_en) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      op_pop_q <= op_pop_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Storage array; no reset needed because the pointers define validity.
  always_ff @(posedge clk) begin
    if (clk_en && wr_en) mem[wr_ptr_q] <= in_data;
  end

  assign done      = done_q;
  assign result    = result_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign dbg_state = state_q;

endmodule

// File: doc/mac_result_fifo.md
# mac_result_fifo

Downstream companion of the MAC pipeline custom instruction. Captures every valid result leaving the MAC pipeline (`NOPOut` low) into a small FIFO. Returns results to the Nios II as a multi-cycle custom instruction (`start`/`done`/`result`) with pop, peek, status and clear operations, so the CPU can drain convolution outputs without matching the pipeline's cadence cycle for cycle.

## Interface
- `DEPTH`, 16, number of FIFO entries; a power of two, at least 2.
- `DATA_W`, 32, width of a MAC result word.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clk_en` in 1: global enable. When low, all state (including input capture) holds.
- `in_nop` in 1: NOP flag from the MAC pipeline output (`NOPOut`). A low value means `in_data` is a valid result.
- `in_data` in `DATA_W`: MAC result (`DataOut`).
- `start` in 1: Nios custom-instruction start; single-cycle pulse.
- `n` in 2: operation select, sampled with `start`.
  - 00 POP
  - 01 STATUS
  - 10 CLEAR
  - 11 PEEK
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: instruction result.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.

## Operation
- Write side: every `clk_en` cycle with `in_nop`=0 writes `in_data` at the tail and increments count. This is unconditional except in two cases:
  - Full with no same-cycle pop: the word is dropped and the sticky `overflow` bit is set.
  - Bypass consumption (see Configuration).
- FSM states:
  - IDLE: waits for `start`.
  - RESP: drives `done` for one cycle.
  - WAIT: a POP or PEEK was issued while the FIFO was empty.
- IDLE + `start`:
  - POP, non-empty: latch the head, advance the head pointer, go to RESP.
  - PEEK, non-empty: latch the head without popping, go to RESP.
  - POP or PEEK, empty: go to WAIT.
  - STATUS: latch `{overflow, 15'b0, count zero-extended to 16}`, go to RESP.
  - CLEAR: reset pointers and count, clear `overflow`, latch result 0, go to RESP. A write in the same cycle is discarded.
- WAIT: stays until the FIFO becomes non-empty, then behaves as the IDLE POP/PEEK case on the following cycle.
- RESP: `done`=1 and `result` = latched value for exactly one cycle, then back to IDLE.
- `start` outside IDLE is ignored.
- Simultaneous write and pop at full: both happen; count stays DEPTH and there is no overflow.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH+1) bits.
- `result` holds its last value outside `done`.

## Timing
- Reset values:
  - `done`=0, `result`=0, `full`=0, `empty`=1.
  - count=0, overflow=0, state IDLE, pointers 0.
- Write latency: an entry written at edge T is visible to `empty`/`full` and to a pop from cycle T+1.
- Non-empty POP/PEEK/STATUS/CLEAR: `start` at cycle T gives `done` at T+1.
- Empty POP without bypass: an entry written at edge W gives head latch at W+1 and `done` at W+2.
- Reset asserted mid-WAIT or mid-RESP: immediately returns to the reset values. No `done` is issued for the aborted instruction.
- With `clk_en` low, the FSM, pointers and `done` all freeze. A pending `done` is extended until `clk_en` returns.

## Configuration
- Macro: `MAC_RESULT_FIFO_BYPASS_EN`.
- Defined:
  - In WAIT for a POP with `in_nop`=0, `in_data` is latched directly into `result` and the FSM goes to RESP. The word is not written to the FIFO, so `done` comes one cycle after the arriving word.
  - PEEK in WAIT still writes the word and is not bypassed.
- Undefined: no bypass path. WAIT always goes through the FIFO, with the latency stated in Timing.

## Test plan
- Write 3 words (0x40a00000, 0x41200000, 0x41700000) then issue 3 POPs:
  - Results come back in order, each `done` at start+1.
  - Then `empty`=1 and STATUS returns 0x00000000.
- Fill 16 entries, write a 17th with no pop:
  - `full`=1 and STATUS returns 0x80000010.
  - The 17th word is never popped.
  - CLEAR then STATUS returns 0x00000000.
- Full FIFO with a pop and a write in the same cycle: count stays 16, `overflow` stays 0, and the FIFO order is preserved.
- POP on empty, then write 0x3f800000 two cycles later:
  - Without the macro: `done` two cycles after the write, result 0x3f800000, count 0.
  - With the macro: `done` one cycle after the word arrives, and count never leaves 0.
- PEEK on head 0x12345678 twice, then POP: all three return 0x12345678, and count drops by one only after the POP.
- Assert `reset` low during WAIT:
  - No `done` pulse; all outputs at their reset values.
  - A subsequent STATUS returns 0x00000000.
